// File: rtl/dec_arb_pkg.sv
// dec_arb_pkg: shared state encoding, widths and round-robin pick for dec_arb_ctrl.
package dec_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    // Scans downward so that the lowest offset from ptr+1 wins; offset N_REQ wraps to ptr itself.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// decoder_3x8: binary-to-one-hot decoder, all zeros when disabled.
module decoder_3x8 (
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out
);

    assign out = en ? 8'b1 << in : 8'b0;

endmodule

// File: rtl/dec_arb_ctrl.sv
// dec_arb_ctrl: 8-way round-robin arbiter with one IDLE cycle between grants.
// Grant tenure timeout (HOLD_MAX cycles, tmo pulse) is built only with DEC_ARB_TIMEOUT_EN.
module dec_arb_ctrl
    import dec_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic [N_REQ-1:0] gnt_oh,
    output logic             tmo
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             done;
    logic             expire;

    assign done = rel | ~req[gnt_idx_q];

`ifdef DEC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    assign expire = cnt_q == CNT_W'(HOLD_MAX - 1);

    always_comb begin
        cnt_d = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
        tmo_d = (state_q == GRANT) & expire & ~done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign expire = 1'b0;
    assign tmo    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d   = GRANT;
                gnt_idx_d = rr_pick(req, ptr_q);
            end
        end else if (done | expire) begin
            state_d = IDLE;
            ptr_d   = gnt_idx_q;
        end
    end

    // ptr resets to 7 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt_vld = state_q == GRANT;
    assign gnt_idx = gnt_idx_q;

    decoder_3x8 u_dec (
        .en (gnt_vld),
        .in (gnt_idx_q),
        .out(gnt_oh)
    );

endmodule

// File: tb/tb_dec_arb_ctrl.sv
// tb_dec_arb_ctrl: scoreboard bench; stimulus queues expected grants, a monitor checks each tenure.
module tb_dec_arb_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt_oh;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int len;
        bit tmo;
        int gap;
    } exp_t;

    exp_t exp_q[$];

    dec_arb_ctrl #(.HOLD_MAX(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .rel    (rel),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .gnt_oh (gnt_oh),
        .tmo    (tmo)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req_v);
        end
    endtask

    task automatic push(input int idx, input int len, input bit t, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.tmo = t;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!gnt_vld && n < 20) begin
            step();
            n++;
        end
        if (!gnt_vld) chk("wait_vld_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        step();
    endtask

    task automatic do_grant(input logic [7:0] r, input int idx, input int hold, input bit drop, input int gap);
        push(idx, hold, 1'b0, gap);
        req = r;
        wait_vld();
        repeat (hold - 1) step();
        if (drop) req = '0;
        else rel = 1;
        step();
        rel = 0;
        req = '0;
        step();
    endtask

    task automatic rel_loop(input logic [7:0] r, input int n);
        req = r;
        for (int k = 0; k < n; k++) begin
            wait_vld();
            rel = 1;
            step();
            rel = 0;
        end
        req = '0;
        step();
    endtask

    // Monitor: one scoreboard entry per grant tenure, checked at its start and end.
    initial begin
        exp_t cur;
        bit   active = 0;
        bit   prev_vld = 0;
        bit   stable = 1;
        int   len = 0;
        int   gap = 0;
        forever begin
            @(negedge clk);
            if (gnt_vld && !prev_vld) begin
                if (tmo) chk("tmo_at_grant", int'(tmo), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_grant", exp_q.size(), 1);
                    active = 0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("gnt_idx", int'(gnt_idx), cur.idx);
                    chk("gnt_oh", int'(gnt_oh), 1 << cur.idx);
                    if (cur.gap >= 0) chk("idle_gap", gap, cur.gap);
                    active = 1;
                end
                len = 1;
                stable = 1;
            end else if (gnt_vld) begin
                len++;
                if (active && int'(gnt_idx) != cur.idx) stable = 0;
            end else if (prev_vld) begin
                if (active) begin
                    chk("tmo_end", int'(tmo), int'(cur.tmo));
                    if (cur.len > 0) chk("tenure", len, cur.len);
                    chk("idx_stable", int'(stable), 1);
                end
                chk("oh_idle", int'(gnt_oh), 0);
                active = 0;
                gap = 1;
            end else begin
                if (tmo) chk("stray_tmo", int'(tmo), 0);
                gap++;
            end
            prev_vld = gnt_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        req   = '0;
        rel   = 0;
        repeat (2) step();
        chk("rst_vld", int'(gnt_vld), 0);
        chk("rst_oh", int'(gnt_oh), 0);
        chk("rst_tmo", int'(tmo), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        rst_n = 1;
        step();
        do_grant(8'h01, 0, 1, 0, -1);
        do_reset();
        push(0, 1, 0, -1);
        for (int k = 1; k <= 8; k++) push(k % 8, 1, 0, 1);
        rel_loop(8'hFF, 9);
        do_grant(8'h40, 6, 1, 0, -1);
        push(0, 1, 0, -1);
        push(6, 1, 0, 1);
        rel_loop(8'h41, 2);
        do_grant(8'h04, 2, 3, 1, -1);
        push(4, 3, 0, -1);
        req = 8'h10;
        wait_vld();
        req = 8'h1F;
        repeat (2) step();
        rel = 1;
        step();
        rel = 0;
        req = '0;
        step();
        rel = 1;
        step();
        rel = 0;
        step();
        do_grant(8'h80, 7, 2, 0, -1);
`ifdef DEC_ARB_TIMEOUT_EN
        push(3, 4, 1, -1);
        push(3, 4, 1, 1);
        push(3, 4, 0, 1);
        req = 8'h08;
        wait_vld();
        repeat (4) step();
        wait_vld();
        repeat (4) step();
        wait_vld();
        repeat (3) step();
        rel = 1;
        step();
        rel = 0;
        req = '0;
        step();
`else
        do_grant(8'h08, 3, 6, 0, -1);
`endif
        push(5, 0, 0, -1);
        req = 8'h20;
        wait_vld();
        step();
        #3;
        rst_n = 0;
        #1;
        chk("mid_rst_vld", int'(gnt_vld), 0);
        chk("mid_rst_oh", int'(gnt_oh), 0);
        chk("mid_rst_tmo", int'(tmo), 0);
        chk("mid_rst_idx", int'(gnt_idx), 0);
        repeat (2) step();
        push(5, 1, 0, -1);
        rst_n = 1;
        rel_loop(8'h20, 1);
        do_reset();
        push(5, 1, 0, -1);
        rel_loop(8'h60, 1);
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_arb_ctrl.md
DEC_ARB_CTRL -- requirements
Module: dec_arb_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, giving the maximum grant tenure in cycles (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 8, with one request line per requester; level-sensitive.
REQ-005 The block SHALL have port rel, input, 1, the release strobe from the current grant holder.
REQ-006 The block SHALL have port gnt_idx, output, 3, the binary index of the granted requester.
REQ-007 The block SHALL have port gnt_vld, output, 1, asserted while a grant is held.
REQ-008 The block SHALL have port gnt_oh, output, 8, the one-hot grant (decoded gnt_idx, gated by gnt_vld).
REQ-009 The block SHALL have port tmo, output, 1, a one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 In IDLE with req != 0, the block SHALL select a winner by round-robin starting at (ptr+1) mod 8, wrapping 7->0, and register gnt_idx; the next state is GRANT.
REQ-012 gnt_vld SHALL assert in the cycle after the req sample, giving 1-cycle latency; gnt_oh SHALL equal 1<<gnt_idx when gnt_vld=1 and 0 otherwise.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE, and gnt_idx SHALL hold its last value.
REQ-014 In GRANT, the block SHALL return to IDLE on rel=1, on req[gnt_idx]=0 (requester drop), or on timeout; on exit, ptr SHALL load gnt_idx.
REQ-015 gnt_vld SHALL be 0 for at least one IDLE cycle between consecutive grants; back-to-back grants therefore occur no more than once every 2 cycles.
REQ-016 A tenure counter SHALL clear on entry to GRANT and increment each GRANT cycle; timeout occurs in the GRANT cycle where the counter equals HOLD_MAX-1.
REQ-017 tmo SHALL pulse for 1 cycle, coincident with the transition GRANT->IDLE caused by timeout only.
REQ-018 If rel or a requester drop coincides with timeout, the block SHALL treat it as a normal release with tmo=0.
REQ-019 rel asserted in IDLE SHALL be ignored.
REQ-020 A change in req during GRANT SHALL NOT alter gnt_idx, except for the drop exit in REQ-014.

Reset
REQ-021 Asserting rst_n=0 SHALL force, asynchronously: state=IDLE, ptr=7 (requester 0 has first priority), gnt_idx=0, gnt_vld=0, gnt_oh=0, tmo=0, and tenure counter=0.
REQ-022 Reset in GRANT SHALL drop the grant immediately, with no tmo pulse; the first arbitration after deassertion SHALL start from requester 0.

Configuration
REQ-023 Macro DEC_ARB_TIMEOUT_EN SHALL control the timeout feature.
REQ-024 With DEC_ARB_TIMEOUT_EN defined, the tenure counter and timeout behaviour SHALL be present as specified.
REQ-025 Without DEC_ARB_TIMEOUT_EN, the block SHALL have no tenure counter, tmo SHALL be tied to 0, HOLD_MAX SHALL be unused, and a grant SHALL end only on rel or a requester drop.

Structure
REQ-026 Shared package dec_arb_pkg SHALL hold: the state encoding (IDLE=0, GRANT=1), N_REQ=8, IDX_W=3, and the tenure counter width (8).
REQ-027 One sub-module, decoder_3x8, SHALL be instantiated: inputs en, in[2:0]; output out[7:0], one-hot when en=1 and all zeros when en=0. It drives gnt_oh from gnt_idx and gnt_vld.
REQ-028 The round-robin winner select SHALL be combinational from req and ptr; all outputs except gnt_oh SHALL be registered.

Verification
REQ-029 After reset with req=8'h01: gnt_vld=1 and gnt_idx=0 one cycle later, and gnt_oh=8'h01.
REQ-030 With req=8'hFF held and rel pulsed each time gnt_vld=1: grants SHALL follow 0,1,...,7,0, each separated by one IDLE cycle.
REQ-031 With ptr=6 and req=8'h41: the grant SHALL go to 0 (wrap past 7), then to 6 on the next arbitration.
REQ-032 With the macro defined, HOLD_MAX=4, req=8'h08 held, and no rel: gnt_vld high 4 cycles, tmo pulses on the 4th, and idx 3 is regranted after 1 IDLE cycle.
REQ-033 With the same setup as REQ-032 but rel=1 in the 4th GRANT cycle: tmo=0.
REQ-034 With rst_n dropped mid-GRANT at idx=5 while req=8'h20: gnt_vld, gnt_oh, and tmo are 0 immediately; after release, idx 5 is granted following the priority order from 0.
